// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave front end: synchronises sck/mosi/ssel into clk, deserialises MSB-first words, serialises driver replies.
// Latency: input edge to registered effect SYNC_STAGES+1 clk; tx_data is sampled 2 clk after data_needed.
// Backpressure: none; the driver must present tx_data in time, and clk must run at least 8x the sck rate.
module spi_slave_byte_if #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             mosi,
    input  logic             ssel,
    output logic             miso,
    output logic             miso_oe,
    output logic             byte_received,
    output logic [WIDTH-1:0] rx_data,
    output logic             data_needed,
    input  logic [WIDTH-1:0] tx_data,
    output logic             frame_active,
    output logic             frame_end
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ssel_sync;
    logic                   sck_prev, ssel_prev;
    logic                   sck_cur, ssel_cur, mosi_cur;
    logic                   sck_rise, sck_fall, ssel_rise, ssel_fall;

    state_t             state, state_nxt;
    logic [CW-1:0]      bit_cnt, bit_cnt_nxt;
    logic [WIDTH-2:0]   rx_shift, rx_shift_nxt;
    logic [WIDTH-1:0]   rx_word;
    logic [WIDTH-1:0]   rx_data_nxt;
    logic [WIDTH-1:0]   tx_shift, tx_shift_nxt;
    logic               byte_received_nxt, data_needed_nxt, frame_end_nxt;
    logic [1:0]         reload_dly;

    // ssel idles high, so its chain resets to 1 to avoid a false frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ssel_sync <= '1;
            sck_prev  <= 1'b0;
            ssel_prev <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], ssel};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
            ssel_prev <= ssel_sync[SYNC_STAGES-1];
        end
    end

    assign sck_cur   = sck_sync[SYNC_STAGES-1];
    assign ssel_cur  = ssel_sync[SYNC_STAGES-1];
    assign mosi_cur  = mosi_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_cur & ~sck_prev;
    assign sck_fall  = ~sck_cur & sck_prev;
    assign ssel_rise = ssel_cur & ~ssel_prev;
    assign ssel_fall = ~ssel_cur & ssel_prev;
    assign rx_word   = {rx_shift, mosi_cur};

    always_comb begin
        state_nxt         = state;
        bit_cnt_nxt       = bit_cnt;
        rx_shift_nxt      = rx_shift;
        rx_data_nxt       = rx_data;
        tx_shift_nxt      = tx_shift;
        byte_received_nxt = 1'b0;
        data_needed_nxt   = 1'b0;
        frame_end_nxt     = 1'b0;
        if (reload_dly[1]) begin
            tx_shift_nxt = tx_data;
        end
        case (state)
            IDLE: begin
                if (ssel_fall) begin
                    state_nxt       = ACTIVE;
                    bit_cnt_nxt     = '0;
                    data_needed_nxt = 1'b1;
                end
            end
            ACTIVE: begin
                // ssel rise wins over any coincident sck edge; a partial word is dropped
                if (ssel_rise) begin
                    state_nxt     = IDLE;
                    bit_cnt_nxt   = '0;
                    frame_end_nxt = 1'b1;
                end else if (sck_rise) begin
                    rx_shift_nxt = rx_word[WIDTH-2:0];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt       = '0;
                        rx_data_nxt       = rx_word;
                        byte_received_nxt = 1'b1;
                        data_needed_nxt   = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CW'(1);
                    end
                end else if (sck_fall && bit_cnt != '0 && !reload_dly[1]) begin
                    tx_shift_nxt = {tx_shift[WIDTH-2:0], 1'b0};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            rx_data       <= '0;
            tx_shift      <= '0;
            byte_received <= 1'b0;
            data_needed   <= 1'b0;
            frame_end     <= 1'b0;
            reload_dly    <= '0;
        end else begin
            state         <= state_nxt;
            bit_cnt       <= bit_cnt_nxt;
            rx_shift      <= rx_shift_nxt;
            rx_data       <= rx_data_nxt;
            tx_shift      <= tx_shift_nxt;
            byte_received <= byte_received_nxt;
            data_needed   <= data_needed_nxt;
            frame_end     <= frame_end_nxt;
            reload_dly    <= {reload_dly[0], data_needed};
        end
    end

    assign frame_active = (state == ACTIVE);
    assign miso_oe      = frame_active;
    assign miso         = frame_active & tx_shift[WIDTH-1];

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Bench for spi_slave_byte_if: a master task drives frames, a reply-queue driver answers data_needed,
// and a scoreboard checks received words, replies seen on miso and pulse rules every clock.
module tb_spi_slave_byte_if;

    localparam int W    = 8;
    localparam int HALF = 5;

    logic         clk = 1'b0;
    logic         rst_n, sck, mosi, ssel;
    logic         miso, miso_oe, byte_received, data_needed, frame_active, frame_end;
    logic [W-1:0] rx_data, tx_data;

    spi_slave_byte_if #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sck           (sck),
        .mosi          (mosi),
        .ssel          (ssel),
        .miso          (miso),
        .miso_oe       (miso_oe),
        .byte_received (byte_received),
        .rx_data       (rx_data),
        .data_needed   (data_needed),
        .tx_data       (tx_data),
        .frame_active  (frame_active),
        .frame_end     (frame_end)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_br = 0, n_dn = 0, n_fe = 0;

    logic [W-1:0] byte_q[$];
    logic [W-1:0] reply_q[$];
    logic [W-1:0] miso_exp_q[$];
    logic [W-1:0] model_rx = '0;
    logic         br_prev = 1'b0, dn_prev = 1'b0, fe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver side: answer each data_needed with the next queued reply
    always @(negedge clk) begin
        if (rst_n && data_needed) begin
            n_dn++;
            if (reply_q.size() != 0) tx_data = reply_q.pop_front();
            else                     tx_data = '0;
            miso_exp_q.push_back(tx_data);
        end
    end

    // scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            model_rx = '0;
            br_prev  = 1'b0;
            dn_prev  = 1'b0;
            fe_prev  = 1'b0;
        end else begin
            check("oe_eq_active", 32'(miso_oe), 32'(frame_active));
            if (!frame_active) begin
                check("miso_idle", 32'(miso), 0);
                check("dn_idle", 32'(data_needed), 0);
                check("br_idle", 32'(byte_received), 0);
            end
            check("dn_width", 32'(data_needed & dn_prev), 0);
            check("br_width", 32'(byte_received & br_prev), 0);
            check("fe_width", 32'(frame_end & fe_prev), 0);
            if (byte_received) begin
                n_br++;
                check("br_expected", 32'(byte_q.size() != 0), 1);
                if (byte_q.size() != 0) model_rx = byte_q.pop_front();
            end
            if (frame_end) n_fe++;
            check("rx_data", 32'(rx_data), 32'(model_rx));
            br_prev = byte_received;
            dn_prev = data_needed;
            fe_prev = frame_end;
        end
    end

    task automatic start_frame();
        ssel = 1'b0;
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (HALF) @(negedge clk);
        ssel = 1'b1;
        repeat (2*HALF) @(negedge clk);
        check("dangling_reply", 32'(miso_exp_q.size()), 1);
        miso_exp_q.delete();
    endtask

    // mode 0 master: mosi changes while sck low, miso sampled on sck rise
    task automatic send_word(input logic [W-1:0] d, input int nbits, output logic [W-1:0] got);
        logic [W-1:0] exp;
        got = '0;
        if (nbits == W) byte_q.push_back(d);
        for (int i = 0; i < nbits; i++) begin
            mosi = d[W-1-i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            got = {got[W-2:0], miso};
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        if (nbits == W) begin
            check("reply_avail", 32'(miso_exp_q.size() != 0), 1);
            exp = (miso_exp_q.size() != 0) ? miso_exp_q.pop_front() : 'x;
            check("miso_word", 32'(got), 32'(exp));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(miso), 0);
        check({tag, "_miso_oe"}, 32'(miso_oe), 0);
        check({tag, "_br"}, 32'(byte_received), 0);
        check({tag, "_rx_data"}, 32'(rx_data), 0);
        check({tag, "_dn"}, 32'(data_needed), 0);
        check({tag, "_active"}, 32'(frame_active), 0);
        check({tag, "_fe"}, 32'(frame_end), 0);
    endtask

    initial begin
        logic [W-1:0] got;
        int br0, dn0, fe0;
        rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; ssel = 1'b0; tx_data = '0;

        // reset with sck toggling and ssel low
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            sck = ~sck; mosi = ~mosi;
            @(negedge clk);
            check_reset_outputs("rst");
        end
        ssel = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_outputs("post_rst");
        check("post_rst_dn_count", 32'(n_dn), 0);

        // single byte
        br0 = n_br; dn0 = n_dn; fe0 = n_fe;
        reply_q = '{8'h3C};
        start_frame();
        check("t2_active", 32'(frame_active), 1);
        check("t2_oe", 32'(miso_oe), 1);
        send_word(8'hA5, W, got);
        check("t2_miso_lit", 32'(got), 32'h3C);
        end_frame();
        check("t2_rx_lit", 32'(rx_data), 32'hA5);
        check("t2_br_cnt", 32'(n_br - br0), 1);
        check("t2_dn_cnt", 32'(n_dn - dn0), 2);
        check("t2_fe_cnt", 32'(n_fe - fe0), 1);
        check("t2_inactive", 32'(frame_active), 0);

        // back-to-back words, driver echoing the previous word
        br0 = n_br; dn0 = n_dn; fe0 = n_fe;
        reply_q = '{8'h00, 8'h01, 8'h80, 8'hFF};
        start_frame();
        send_word(8'h01, W, got);
        check("t3_miso0_lit", 32'(got), 32'h00);
        send_word(8'h80, W, got);
        check("t3_miso1_lit", 32'(got), 32'h01);
        send_word(8'hFF, W, got);
        check("t3_miso2_lit", 32'(got), 32'h80);
        end_frame();
        check("t3_rx_lit", 32'(rx_data), 32'hFF);
        check("t3_br_cnt", 32'(n_br - br0), 3);
        check("t3_dn_cnt", 32'(n_dn - dn0), 4);
        check("t3_fe_cnt", 32'(n_fe - fe0), 1);

        // abort mid-word, then a clean frame
        br0 = n_br; fe0 = n_fe;
        start_frame();
        send_word(8'hF0, 5, got);
        end_frame();
        check("t4_br_cnt", 32'(n_br - br0), 0);
        check("t4_rx_hold_lit", 32'(rx_data), 32'hFF);
        check("t4_fe_cnt", 32'(n_fe - fe0), 1);
        reply_q = '{8'h5A};
        start_frame();
        send_word(8'h55, W, got);
        check("t4_miso_lit", 32'(got), 32'h5A);
        end_frame();
        check("t4_rx_lit", 32'(rx_data), 32'h55);

        // sck noise while deselected
        br0 = n_br; dn0 = n_dn; fe0 = n_fe;
        for (int i = 0; i < 20; i++) begin
            sck = ~sck; mosi = 1'($urandom_range(1));
            repeat (HALF) @(negedge clk);
            check("t5_miso", 32'(miso), 0);
            check("t5_oe", 32'(miso_oe), 0);
        end
        sck = 1'b0;
        repeat (HALF) @(negedge clk);
        check("t5_br_cnt", 32'(n_br - br0), 0);
        check("t5_dn_cnt", 32'(n_dn - dn0), 0);
        check("t5_fe_cnt", 32'(n_fe - fe0), 0);
        check("t5_rx_hold_lit", 32'(rx_data), 32'h55);

        // reset in the middle of a frame
        start_frame();
        send_word(8'h96, 4, got);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("t6_rst");
        ssel = 1'b1; sck = 1'b0;
        repeat (4) @(negedge clk);
        byte_q.delete();
        miso_exp_q.delete();
        reply_q.delete();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_outputs("t6_post");
        br0 = n_br;
        reply_q = '{8'h81};
        start_frame();
        send_word(8'hC3, W, got);
        check("t6_miso_lit", 32'(got), 32'h81);
        end_frame();
        check("t6_rx_lit", 32'(rx_data), 32'hC3);
        check("t6_br_cnt", 32'(n_br - br0), 1);

        check("final_byte_q_empty", 32'(byte_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
